rmst_serializer: RTL and testbench

RMST_SERIALIZER -- requirements
Module: rom_serializer

---
 rtl/rmst_serializer.sv | 148 ++++++++++++++
 tb/tb_rmst_serializer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rmst_serializer.sv
// ROM-to-serial streamer: fetches words from a combinational ROM and shifts them out MSB first
// with a divided serial clock, either one word at sel_addr or a burst over the whole ROM.
module rmst_serializer #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int HALF_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              single,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              sclk,
  output logic              sdata,
  output logic              frame,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DIV_W = $clog2(2 * HALF_DIV);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * HALF_DIV - 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              single_q, single_d;
  logic [DATA_W-1:0] shreg_q,  shreg_d;
  logic              sdata_q,  sdata_d;
  logic              sclk_q,   sclk_d;
  logic [DIV_W-1:0]  div_q,    div_d;
  logic [BIT_W-1:0]  bit_q,    bit_d;
  logic [DATA_W-1:0] shreg_shifted;

  assign shreg_shifted = shreg_q << 1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    single_d = single_q;
    shreg_d  = shreg_q;
    sdata_d  = sdata_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    bit_d    = bit_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          single_d = single;
          addr_d   = single ? sel_addr : '0;
        end
      end
      S_FETCH: begin
        // The first bit is presented directly so it appears on the first SHIFT cycle.
        state_d = S_SHIFT;
        shreg_d = rom_data;
        sdata_d = rom_data[DATA_W-1];
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_LAST) begin
            sdata_d = 1'b0;
            // Bursts stop at the top address rather than wrapping.
            if (!single_q && (addr_q != '1)) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_shifted;
            sdata_d = shreg_shifted[DATA_W-1];
          end
        end else begin
          div_d = div_q + DIV_W'(1);
          if (div_q == HALF_LAST) begin
            sclk_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      single_d = 1'b0;
      shreg_d  = '0;
      sdata_d  = 1'b0;
      sclk_d   = 1'b0;
      div_d    = '0;
      bit_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      single_q <= 1'b0;
      shreg_q  <= '0;
      sdata_q  <= 1'b0;
      sclk_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      single_q <= single_d;
      shreg_q  <= shreg_d;
      sdata_q  <= sdata_d;
      sclk_q   <= sclk_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
    end
  end

  assign rom_addr = addr_q;
  assign sclk     = sclk_q;
  assign sdata    = sdata_q;
  assign frame    = (state_q == S_SHIFT);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_rmst_serializer.sv
// Directed bench for rmst_serializer: default-divider instance plus a HALF_DIV=1 instance,
// each fed by its own small ROM model.
module tb_rmst_serializer;

  logic        clk = 1'b0;
  logic        rst, start, single, abort;
  logic [2:0]  sel_addr, rom_addr;
  logic [15:0] rom_data;
  logic        sclk, sdata, frame, busy, done;

  logic        start1, single1, abort1;
  logic [2:0]  sel_addr1, rom_addr1;
  logic [15:0] rom_data1;
  logic        sclk1, sdata1, frame1, busy1, done1;

  logic [15:0] rom  [0:7];
  logic [15:0] rom1 [0:7];

  int checks   = 0;
  int failures = 0;

  assign rom_data  = rom[rom_addr];
  assign rom_data1 = rom1[rom_addr1];

  always #5 clk = ~clk;

  rmst_serializer #(.DATA_W(16), .ADDR_W(3), .HALF_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .single(single), .sel_addr(sel_addr),
    .abort(abort), .rom_addr(rom_addr), .rom_data(rom_data), .sclk(sclk),
    .sdata(sdata), .frame(frame), .busy(busy), .done(done)
  );

  rmst_serializer #(.DATA_W(16), .ADDR_W(3), .HALF_DIV(1)) u_dut_hd1 (
    .clk(clk), .rst(rst), .start(start1), .single(single1), .sel_addr(sel_addr1),
    .abort(abort1), .rom_addr(rom_addr1), .rom_data(rom_data1), .sclk(sclk1),
    .sdata(sdata1), .frame(frame1), .busy(busy1), .done(done1)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, frame, sclk, sdata, rom_addr} !== 8'b0) begin
      failures++;
      $display("FAIL reset_dut got=%b want=%b", {busy, done, frame, sclk, sdata, rom_addr}, 8'b0);
    end
    checks++;
    if ({busy1, done1, frame1, sclk1, sdata1, rom_addr1} !== 8'b0) begin
      failures++;
      $display("FAIL reset_hd1 got=%b want=%b", {busy1, done1, frame1, sclk1, sdata1, rom_addr1}, 8'b0);
    end
    rst = 1'b0;
    $display("reset: outputs checked in reset state");
  endtask

  task automatic test_single();
    logic [15:0] w;
    logic [4:0]  exp, obs;
    w = 16'hA5C3;
    rom[5] = w;
    single = 1'b1; sel_addr = 3'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, frame, sclk, rom_addr} !== {1'b1, 1'b0, 1'b0, 3'd5}) begin
      failures++;
      $display("FAIL single_fetch got=%b want=%b", {busy, frame, sclk, rom_addr}, {1'b1, 1'b0, 1'b0, 3'd5});
    end
    for (int c = 2; c <= 65; c++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b1, ((c - 2) % 4) >= 2, w[15 - (c - 2) / 4]};
      obs = {busy, done, frame, sclk, sdata};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single_shift cyc=%0d got=%b want=%b", c, obs, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, done, frame, sclk} !== 4'b1100) begin
      failures++;
      $display("FAIL single_done got=%b want=1100", {busy, done, frame, sclk});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL single_idle got=%b want=00", {busy, done});
    end
    $display("single: addr=5 word=%h shifted, done on cycle 66", w);
  endtask

  task automatic test_burst();
    logic [15:0] w;
    logic [4:0]  exp, obs;
    for (int i = 0; i < 8; i++) rom[i] = 16'(16'h1111 * i);
    single = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      checks++;
      if ({busy, done, frame, sclk, rom_addr} !== {4'b1000, 3'(k)}) begin
        failures++;
        $display("FAIL burst_fetch word=%0d got=%b want=%b", k, {busy, done, frame, sclk, rom_addr}, {4'b1000, 3'(k)});
      end
      w = rom[k];
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        exp = {1'b1, 1'b0, 1'b1, (c % 4) >= 2, w[15 - c / 4]};
        obs = {busy, done, frame, sclk, sdata};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL burst_shift word=%0d cyc=%0d got=%b want=%b", k, c, obs, exp);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({busy, done, frame, rom_addr} !== {3'b110, 3'd7}) begin
      failures++;
      $display("FAIL burst_done got=%b want=%b", {busy, done, frame, rom_addr}, {3'b110, 3'd7});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL burst_idle got=%b want=00", {busy, done});
    end
    $display("burst: 8 words streamed, one done pulse");
  endtask

  task automatic test_start_held();
    single = 1'b0; start = 1'b1;
    for (int c = 1; c <= 521; c++) begin
      @(negedge clk);
      checks++;
      if ({busy, done} !== {1'b1, c == 521}) begin
        failures++;
        $display("FAIL held_busy cyc=%0d got=%b want=%b", c, {busy, done}, {1'b1, c == 521});
      end
      if (c == 456) begin
        checks++;
        if ({frame, rom_addr} !== {1'b0, 3'd7}) begin
          failures++;
          $display("FAIL held_last_fetch got=%b want=%b", {frame, rom_addr}, {1'b0, 3'd7});
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL held_idle got=%b want=0", busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, frame, rom_addr} !== 5'b10000) begin
      failures++;
      $display("FAIL held_restart got=%b want=10000", {busy, frame, rom_addr});
    end
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, rom_addr} !== 5'b0) begin
      failures++;
      $display("FAIL held_abort_fetch got=%b want=00000", {busy, done, rom_addr});
    end
    $display("start_held: one burst, restart after idle, abort in fetch");
  endtask

  task automatic test_abort();
    logic seen;
    single = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 2; c <= 206; c++) @(negedge clk);
    checks++;
    if ({frame, sclk, sdata, rom_addr} !== {3'b101, 3'd3}) begin
      failures++;
      $display("FAIL abort_pre got=%b want=%b", {frame, sclk, sdata, rom_addr}, {3'b101, 3'd3});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done, frame, sclk, sdata, rom_addr} !== 8'b0) begin
      failures++;
      $display("FAIL abort_outputs got=%b want=00000000", {busy, done, frame, sclk, sdata, rom_addr});
    end
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet got=%b want=0", seen);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_priority got=%b want=0", busy);
    end
    $display("abort: cancelled word 3 shift cycle 10, abort beats start");
  endtask

  task automatic test_rst_mid();
    single = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, frame, sclk, sdata, rom_addr} !== 8'b0) begin
      failures++;
      $display("FAIL rst_mid_outputs got=%b want=00000000", {busy, done, frame, sclk, sdata, rom_addr});
    end
    rst = 1'b0; abort = 1'b0; single = 1'b1; sel_addr = 3'd2;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, frame, rom_addr} !== {2'b10, 3'd2}) begin
      failures++;
      $display("FAIL rst_mid_accept got=%b want=%b", {busy, frame, rom_addr}, {2'b10, 3'd2});
    end
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid_cleanup got=%b want=00", {busy, done});
    end
    $display("rst_mid: reset beats abort/start, start accepted right after");
  endtask

  task automatic test_half_div1();
    logic [15:0] w;
    logic [4:0]  exp, obs;
    w = 16'h8001;
    rom1[3] = w;
    single1 = 1'b1; sel_addr1 = 3'd3; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    checks++;
    if ({busy1, frame1, sclk1, rom_addr1} !== {3'b100, 3'd3}) begin
      failures++;
      $display("FAIL hd1_fetch got=%b want=%b", {busy1, frame1, sclk1, rom_addr1}, {3'b100, 3'd3});
    end
    for (int c = 2; c <= 33; c++) begin
      @(negedge clk);
      exp = {1'b1, 1'b0, 1'b1, ((c - 2) % 2) == 1, w[15 - (c - 2) / 2]};
      obs = {busy1, done1, frame1, sclk1, sdata1};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL hd1_shift cyc=%0d got=%b want=%b", c, obs, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({busy1, done1, frame1} !== 3'b110) begin
      failures++;
      $display("FAIL hd1_done got=%b want=110", {busy1, done1, frame1});
    end
    @(negedge clk);
    checks++;
    if ({busy1, done1} !== 2'b00) begin
      failures++;
      $display("FAIL hd1_idle got=%b want=00", {busy1, done1});
    end
    $display("half_div1: word %h shifted, done on cycle 34", w);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; single = 1'b0; abort = 1'b0; sel_addr = 3'd0;
    start1 = 1'b0; single1 = 1'b0; abort1 = 1'b0; sel_addr1 = 3'd0;
    for (int i = 0; i < 8; i++) begin
      rom[i]  = 16'h0000;
      rom1[i] = 16'h0000;
    end
    test_reset();
    test_single();
    test_burst();
    test_start_held();
    test_abort();
    test_rst_mid();
    test_half_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
